switch_link_tx: RTL



---
 rtl/chiplet_types_pkg.sv | 13 +
 rtl/switch_link_tx_pkg.sv | 9 +
 rtl/switch_link_tx_if.sv | 25 ++
 rtl/switch_link_tx_credit_counter.sv | 43 ++++
 rtl/switch_link_tx.sv | 123 ++++++++++++
 5 files changed

// File: rtl/chiplet_types_pkg.sv
// Shared link types for the chiplet switch fabric: flit format and VC field width.
// LINK_VC_W must be wide enough to encode every VC of the widest link in the system.
package chiplet_types_pkg;

  localparam int LINK_VC_W   = 1;
  localparam int FLIT_DATA_W = 32;

  typedef struct packed {
    logic [LINK_VC_W-1:0]   vc;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;

endpackage

// File: rtl/switch_link_tx_pkg.sv
// Local definitions for the switch link transmitter: FSM state encoding.
package switch_link_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/switch_link_tx_if.sv
// Source-side flit handshake into the link transmitter.
// master = packet source, slave = switch_link_tx.
interface switch_link_tx_if;
  import chiplet_types_pkg::*;

  logic  src_valid;
  flit_t src_flit;
  logic  src_last;
  logic  src_ready;

  modport master (
    output src_valid,
    output src_flit,
    output src_last,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_flit,
    input  src_last,
    output src_ready
  );

endinterface

// File: rtl/switch_link_tx_credit_counter.sv
// Per-VC saturating credit counter with a sticky overflow flag.
// Starts full because the receiver buffer is empty out of reset.
module link_credit_counter #(
  parameter int BUFFER_SIZE = 8,
  parameter int CW          = $clog2(BUFFER_SIZE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          ovf
);

  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [CW:0]   sum;

  // One extra bit so a return onto a full counter is detectable before saturating.
  always_comb begin
    sum     = {1'b0, count_q} + (CW + 1)'(inc) - (CW + 1)'(dec);
    count_d = sum[CW-1:0];
    ovf_d   = ovf_q;
    if (sum > (CW + 1)'(BUFFER_SIZE)) begin
      count_d = CW'(BUFFER_SIZE);
      ovf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CW'(BUFFER_SIZE);
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/switch_link_tx.sv
// Transmit side of a switch link: wormhole VC locking, per-VC credit flow control
// and a registered flit/data_ready output stage.
module switch_link_tx
  import chiplet_types_pkg::*;
  import switch_link_tx_pkg::*;
#(
  parameter  int NUM_VCS     = 2,
  parameter  int BUFFER_SIZE = 8,
  localparam int CW          = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  switch_link_tx_if.slave        src,
  output flit_t                  tx_out,
  output logic                   data_ready_out,
  input  logic [NUM_VCS-1:0]     credit_granted,
  output logic                   packet_sent,
  output logic [NUM_VCS*CW-1:0]  credits,
  output logic                   busy,
  output logic                   err_credit_ovf
);

  tx_state_e            state_q, state_d;
  logic [LINK_VC_W-1:0] locked_vc_q, locked_vc_d;
  flit_t                tx_q, tx_d;
  logic                 data_ready_q, data_ready_d;
  logic                 packet_sent_q, packet_sent_d;

  logic [LINK_VC_W-1:0] tgt;
  logic                 ready;
  logic                 accept;
  logic [NUM_VCS-1:0]   dec;
  logic [NUM_VCS-1:0]   ovf;
  logic [CW-1:0]        cnt [NUM_VCS];

  // Once a head is accepted the packet stays on its VC, whatever later flits claim.
  assign tgt = (state_q == ST_IDLE) ? src.src_flit.vc : locked_vc_q;

  always_comb begin
    ready = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (tgt == LINK_VC_W'(v)) begin
        ready = (cnt[v] != '0);
      end
    end
  end

  assign accept        = src.src_valid && ready;
  assign src.src_ready = ready;

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      dec[v] = accept && (tgt == LINK_VC_W'(v));
    end
  end

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_credit
    link_credit_counter #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .CW          (CW)
    ) u_credit (
      .clk   (clk),
      .rst   (rst),
      .dec   (dec[v]),
      .inc   (credit_granted[v]),
      .count (cnt[v]),
      .ovf   (ovf[v])
    );
    assign credits[v*CW +: CW] = cnt[v];
  end

  assign err_credit_ovf = |ovf;

  always_comb begin
    state_d       = state_q;
    locked_vc_d   = locked_vc_q;
    tx_d          = '0;
    data_ready_d  = 1'b0;
    packet_sent_d = 1'b0;
    if (accept) begin
      tx_d          = src.src_flit;
      tx_d.vc       = tgt;
      data_ready_d  = 1'b1;
      packet_sent_d = src.src_last;
      case (state_q)
        ST_IDLE: begin
          if (!src.src_last) begin
            state_d     = ST_SEND;
            locked_vc_d = src.src_flit.vc;
          end
        end
        ST_SEND: begin
          if (src.src_last) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      locked_vc_q   <= '0;
      tx_q          <= '0;
      data_ready_q  <= 1'b0;
      packet_sent_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      locked_vc_q   <= locked_vc_d;
      tx_q          <= tx_d;
      data_ready_q  <= data_ready_d;
      packet_sent_q <= packet_sent_d;
    end
  end

  assign tx_out         = tx_q;
  assign data_ready_out = data_ready_q;
  assign packet_sent    = packet_sent_q;
  assign busy           = (state_q == ST_SEND);

endmodule
